// File: rtl/bpsk_symbol_feeder.sv
// Byte FIFO fed by a UART receiver, serialised LSB first into fixed-length
// BPSK symbols with an optional NRZ-M differential encoding.
module bpsk_symbol_feeder #(
  parameter int CLOCK_FREQ  = 12_000_000,
  parameter int SYMBOL_RATE = 1_200_000,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIFF_ENC    = 0
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_ready,
  output logic                          rx_done,
  input  logic                          enable,
  input  logic                          clr_ovf,
  output logic                          sym_bit,
  output logic                          sym_valid,
  output logic                          sym_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          state_dbg
);
  localparam int SYM_CNT = CLOCK_FREQ / SYMBOL_RATE - 1;
  localparam int SCW     = (SYM_CNT > 0) ? $clog2(SYM_CNT + 1) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam logic [SCW-1:0] SYM_LAST = SCW'(SYM_CNT);
  localparam logic [AW:0]    DEPTH    = (AW + 1)'(FIFO_DEPTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [0:0]     state_q, state_d;
  logic [6:0]     sh_q, sh_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [SCW-1:0] sym_cnt_q, sym_cnt_d;
  logic           sym_bit_q, sym_bit_d;
  logic           sym_valid_q, sym_valid_d;
  logic           sym_strobe_q, sym_strobe_d;
  logic           rx_done_q, rx_done_d;
  logic           ovf_q, ovf_d;

  logic       full, push, pop, avail, load, adv, next_bit;
  logic [7:0] head;

  assign full = (count_q == DEPTH);
  assign push = rx_ready & ~rx_done_q & ~full;
  // A byte written on the previous edge is not offered to the reader until
  // one cycle later, so an idle feeder starts two edges after capture.
  assign avail = (count_q > {{AW{1'b0}}, rx_done_q});
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    rx_done_d = push;
    ovf_d     = (ovf_q & ~clr_ovf) | (rx_ready & full & ~rx_done_q);
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    bit_cnt_d    = bit_cnt_q;
    sym_cnt_d    = sym_cnt_q;
    sym_bit_d    = sym_bit_q;
    sym_valid_d  = sym_valid_q;
    sym_strobe_d = 1'b0;
    pop          = 1'b0;
    load         = 1'b0;
    adv          = 1'b0;
    next_bit     = 1'b0;
    case (state_q)
      IDLE: load = enable & avail;
      default: begin
        if (sym_cnt_q == SYM_LAST) begin
          if (bit_cnt_q != 3'd7) begin
            adv = 1'b1;
          end else if (enable && avail) begin
            load = 1'b1;
          end else begin
            state_d     = IDLE;
            sym_valid_d = 1'b0;
          end
        end else begin
          sym_cnt_d = sym_cnt_q + 1'b1;
        end
      end
    endcase
    if (load) begin
      pop          = 1'b1;
      state_d      = SHIFT;
      sh_d         = head[7:1];
      bit_cnt_d    = 3'd0;
      sym_cnt_d    = '0;
      sym_valid_d  = 1'b1;
      sym_strobe_d = 1'b1;
      next_bit     = head[0];
    end
    if (adv) begin
      sh_d         = {1'b0, sh_q[6:1]};
      bit_cnt_d    = bit_cnt_q + 1'b1;
      sym_cnt_d    = '0;
      sym_strobe_d = 1'b1;
      next_bit     = sh_q[0];
    end
    // NRZ-M: the previous symbol persists across bytes and idle gaps.
    if (load || adv) sym_bit_d = (DIFF_ENC != 0) ? (sym_bit_q ^ next_bit) : next_bit;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      sym_cnt_q    <= '0;
      sym_bit_q    <= 1'b0;
      sym_valid_q  <= 1'b0;
      sym_strobe_q <= 1'b0;
      rx_done_q    <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      sh_q         <= sh_d;
      bit_cnt_q    <= bit_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      sym_bit_q    <= sym_bit_d;
      sym_valid_q  <= sym_valid_d;
      sym_strobe_q <= sym_strobe_d;
      rx_done_q    <= rx_done_d;
      ovf_q        <= ovf_d;
    end
  end

  assign rx_done    = rx_done_q;
  assign sym_bit    = sym_bit_q;
  assign sym_valid  = sym_valid_q;
  assign sym_strobe = sym_strobe_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_bpsk_symbol_feeder.sv
// Bench for bpsk_symbol_feeder: plain and differential instances share inputs;
// per-symbol expectations flow through queues checked on every strobe.
module tb_bpsk_symbol_feeder;
  localparam int SYM_LEN = 10;

  logic       clk, n_rst, rx_ready, enable, clr_ovf;
  logic [7:0] rx_data;
  logic       rx_done, sym_bit, sym_valid, sym_strobe, overflow, state_dbg;
  logic [4:0] fifo_count;
  logic       rx_done1, sym_bit1, sym_valid1, sym_strobe1, overflow1, state_dbg1;
  logic [4:0] fifo_count1;

  bpsk_symbol_feeder #(.DIFF_ENC(0)) u0 (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_ready(rx_ready), .rx_done(rx_done),
    .enable(enable), .clr_ovf(clr_ovf), .sym_bit(sym_bit), .sym_valid(sym_valid),
    .sym_strobe(sym_strobe), .fifo_count(fifo_count), .overflow(overflow), .state_dbg(state_dbg)
  );

  bpsk_symbol_feeder #(.DIFF_ENC(1)) u1 (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_ready(rx_ready), .rx_done(rx_done1),
    .enable(enable), .clr_ovf(clr_ovf), .sym_bit(sym_bit1), .sym_valid(sym_valid1),
    .sym_strobe(sym_strobe1), .fifo_count(fifo_count1), .overflow(overflow1), .state_dbg(state_dbg1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];
  logic [0:0] exp_d_q[$];
  logic       model_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(d[i]);
      model_prev = model_prev ^ d[i];
      exp_d_q.push_back(model_prev);
    end
  endtask

  // monitor for the plain instance: bit values, symbol lengths, run statistics
  int   runs_done = 0, run_len = 0, run_strobes = 0, last_len = 0, last_strobes = 0, spacing = 0;
  bit   in_run = 0, hold_ok = 1;
  logic last_exp = 1'b0;

  always @(negedge clk) begin
    if (!n_rst) begin
      in_run = 0; run_len = 0; run_strobes = 0;
    end else if (sym_valid) begin
      if (sym_strobe) begin
        if (run_strobes > 0) begin
          chk("symbol_len", spacing, SYM_LEN);
          chk("symbol_hold", hold_ok, 1);
        end
        chk("queue_has_symbol", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          last_exp = exp_q.pop_front();
          chk("sym_bit", sym_bit, last_exp);
        end
        spacing = 1; hold_ok = 1; run_strobes++;
      end else begin
        spacing++;
        if (sym_bit !== last_exp) hold_ok = 0;
      end
      run_len++; in_run = 1;
    end else begin
      chk("strobe_without_valid", sym_strobe, 0);
      if (in_run) begin
        chk("last_symbol_len", spacing, SYM_LEN);
        chk("last_symbol_hold", hold_ok, 1);
        last_len = run_len; last_strobes = run_strobes; runs_done++;
      end
      in_run = 0; run_len = 0; run_strobes = 0;
    end
  end

  // monitor for the differential instance
  always @(negedge clk) begin
    logic e;
    if (n_rst && sym_valid1 && sym_strobe1) begin
      chk("diff_queue_has_symbol", exp_d_q.size() > 0, 1);
      if (exp_d_q.size() > 0) begin
        e = exp_d_q.pop_front();
        chk("diff_sym_bit", sym_bit1, e);
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] d, input bit check_latency);
    bit got = 0;
    rx_data  = d;
    rx_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #1;
      if (rx_done) got = 1;
    end
    chk("rx_done_seen", got, 1);
    if (check_latency) chk("valid_at_capture", sym_valid, 0);
    @(negedge clk); #1;
    chk("rx_done_one_cycle", rx_done, 0);
    if (check_latency) chk("valid_at_capture_plus1", sym_valid, 0);
    rx_ready = 1'b0;
    if (check_latency) begin
      @(negedge clk); #1;
      chk("valid_at_capture_plus2", sym_valid, 1);
      chk("strobe_at_capture_plus2", sym_strobe, 1);
      chk("single_write_count", fifo_count, 0);
    end
  endtask

  task automatic wait_run_end(input int bound);
    int  start = runs_done;
    bit  ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk); #1;
      if (runs_done != start) ok = 1;
    end
    chk("run_end_timeout", ok, 1);
  endtask

  task automatic wait_strobes(input int n, input int bound);
    bit ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk); #1;
      if (run_strobes >= n) ok = 1;
    end
    chk("strobe_wait_timeout", ok, 1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_bits;  // bit i = i-th symbol, plain encoding
    logic [7:0] exp_diff;  // bit i = i-th symbol, NRZ-M from a 0 line state
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] ob[16];
    bit seen;

    vecs[0] = '{8'h0F, 8'h0F, 8'h05};
    vecs[1] = '{8'hA5, 8'hA5, 8'h63};
    vecs[2] = '{8'h3C, 8'h3C, 8'h14};
    vecs[3] = '{8'hFF, 8'hFF, 8'h55};
    vecs[4] = '{8'h00, 8'h00, 8'h00};

    n_rst = 1'b0; rx_ready = 1'b0; rx_data = 8'h00; enable = 1'b0; clr_ovf = 1'b0;
    @(negedge clk); #1;
    chk("reset_outputs", {sym_bit, sym_valid, sym_strobe, rx_done, overflow, state_dbg}, 0);
    chk("reset_fifo_count", fifo_count, 0);
    chk("reset_outputs_diff", {sym_bit1, sym_valid1, sym_strobe1, rx_done1, overflow1, state_dbg1}, 0);
    n_rst = 1'b1;
    @(negedge clk); #1;

    // single bytes from idle, table driven
    enable = 1'b1;
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back(vecs[v].exp_bits[i]);
        exp_d_q.push_back(vecs[v].exp_diff[i]);
      end
      model_prev = vecs[v].exp_diff[7];
      send_byte(vecs[v].data, 1'b1);
      wait_run_end(200);
      chk("byte_valid_len", last_len, 8 * SYM_LEN);
      chk("byte_strobes", last_strobes, 8);
      chk("byte_state_idle", state_dbg, 0);
      chk("byte_idle_bit_hold", sym_bit, vecs[v].exp_bits[7]);
      chk("byte_fifo_empty", fifo_count, 0);
    end

    // back-to-back bytes with no gap
    push_exp(8'h01);
    push_exp(8'hFF);
    send_byte(8'h01, 1'b1);
    send_byte(8'hFF, 1'b0);
    wait_run_end(400);
    chk("b2b_valid_len", last_len, 16 * SYM_LEN);
    chk("b2b_strobes", last_strobes, 16);
    chk("b2b_fifo_empty", fifo_count, 0);

    // enable dropped mid-byte: byte completes, next waits
    push_exp(8'h3C);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b0);
    wait_strobes(3, 100);
    enable = 1'b0;
    wait_run_end(200);
    chk("drop_valid_len", last_len, 8 * SYM_LEN);
    chk("drop_strobes", last_strobes, 8);
    chk("drop_fifo_count", fifo_count, 1);
    chk("drop_state_idle", state_dbg, 0);
    repeat (5) @(negedge clk);
    #1;
    chk("drop_still_idle", sym_valid, 0);
    chk("drop_bit_hold", sym_bit, 1'b0);
    push_exp(8'hC3);
    enable = 1'b1;
    @(negedge clk); #1;
    chk("reenable_valid", sym_valid, 1);
    chk("reenable_strobe", sym_strobe, 1);
    wait_run_end(200);
    chk("reenable_fifo_empty", fifo_count, 0);

    // overflow with enable low
    enable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ob[i] = 8'($urandom_range(0, 255));
      send_byte(ob[i], 1'b0);
    end
    chk("full_count", fifo_count, 16);
    chk("full_count_diff", fifo_count1, 16);
    chk("full_no_overflow_yet", overflow, 0);
    rx_data = 8'h5A; rx_ready = 1'b1; seen = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (rx_done) seen = 1;
    end
    chk("no_rx_done_when_full", seen, 0);
    chk("overflow_set", overflow, 1);
    chk("overflow_set_diff", overflow1, 1);
    chk("full_count_kept", fifo_count, 16);
    clr_ovf = 1'b1;
    @(negedge clk); #1;
    chk("overflow_set_wins", overflow, 1);
    rx_ready = 1'b0;
    @(negedge clk); #1;
    chk("overflow_cleared", overflow, 0);
    clr_ovf = 1'b0;
    for (int i = 0; i < 16; i++) push_exp(ob[i]);
    enable = 1'b1;
    wait_run_end(1500);
    chk("drain_valid_len", last_len, 128 * SYM_LEN);
    chk("drain_strobes", last_strobes, 128);
    chk("drain_fifo_empty", fifo_count, 0);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp_d_q_drained", exp_d_q.size(), 0);

    // asynchronous reset in the middle of a byte with more queued
    push_exp(8'h96);
    send_byte(8'h96, 1'b1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    wait_strobes(4, 100);
    repeat (3) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("async_reset_outputs", {sym_bit, sym_valid, sym_strobe, rx_done, overflow}, 0);
    chk("async_reset_fifo_count", fifo_count, 0);
    chk("async_reset_diff", {sym_bit1, sym_valid1, fifo_count1}, 0);
    exp_q.delete();
    exp_d_q.delete();
    model_prev = 1'b0;
    repeat (2) @(negedge clk);
    #1 n_rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (sym_valid || sym_valid1) seen = 1;
    end
    chk("no_symbols_after_reset", seen, 0);
    chk("post_reset_fifo_count", fifo_count, 0);
    chk("post_reset_state", state_dbg, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
